// File: rtl/sub4_serial.sv
// Bit-serial subtractor: diferenca = A - B, one bit per clock, LSB first.
// Optional ovf output enabled by defining SUB4_SERIAL_OVERFLOW_EN.
module sub4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diferenca,
  output logic             borrow
`ifdef SUB4_SERIAL_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra, rb, rr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, br_n;
  logic [WIDTH-1:0] rr_n;
`ifdef SUB4_SERIAL_OVERFLOW_EN
  logic             am, bm;
`endif

  // Full-subtractor cell on the current LSBs; rr_n includes the bit being produced.
  always_comb begin
    d    = ra[0] ^ rb[0] ^ br;
    br_n = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    rr_n = {d, rr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      rr        <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diferenca <= '0;
      borrow    <= 1'b0;
`ifdef SUB4_SERIAL_OVERFLOW_EN
      am        <= 1'b0;
      bm        <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rr  <= rr_n;
          br  <= br_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            diferenca <= rr_n;
            borrow    <= br_n;
`ifdef SUB4_SERIAL_OVERFLOW_EN
            ovf       <= (am != bm) && (rr_n[WIDTH-1] != am);
`endif
          end
        end
        // IDLE and DONE share the accept path, which gives back-to-back starts from DONE.
        default: begin
          done <= 1'b0;
          if (start) begin
            ra    <= A;
            rb    <= B;
            rr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SUB4_SERIAL_OVERFLOW_EN
            am    <= A[WIDTH-1];
            bm    <= B[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub4_serial.sv
// Directed self-checking bench for sub4_serial (WIDTH=4) with a result scoreboard.
module tb_sub4_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B;
  logic         busy, done, borrow;
  logic [W-1:0] diferenca;
`ifdef SUB4_SERIAL_OVERFLOW_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] dif;
    logic         bor;
    logic         ov;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  sub4_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .diferenca(diferenca), .borrow(borrow)
`ifdef SUB4_SERIAL_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dif = a - b;
    e.bor = (a < b);
    e.ov  = (a[W-1] != b[W-1]) && (e.dif[W-1] != a[W-1]);
    sbq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
    if (done === 1'b1) begin
      done_cnt++;
      chk("sb_has_entry_on_done", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("diferenca", diferenca, e.dif);
        chk("borrow", borrow, e.bor);
`ifdef SUB4_SERIAL_OVERFLOW_EN
        chk("ovf", ovf, e.ov);
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 30) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      n++;
    end
    chk("done_within_budget", {31'd0, done === 1'b1}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n, bc;
    A = a; B = b; start = 1'b1;
    push(a, b);
    tick();
    start = 1'b0;
    wait_done(n, bc);
    chk("busy_cycles", bc, W);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, bc, base, gap;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dif", diferenca, 32'd0);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
    rst = 1'b0;
    tick();

    run_op(4'd9, 4'd3);
    chk("plan_9_3", diferenca, 32'd6);
    run_op(4'd3, 4'd9);
    chk("plan_3_9", diferenca, 32'd10);
    run_op(4'd7, 4'd15);
    run_op(4'd5, 4'd5);
    run_op(4'd0, 4'd1);
    chk("plan_0_1", diferenca, 32'd15);
    tick();
    tick();
    chk("hold_idle", diferenca, 32'd15);

    // start and operand changes during SHIFT must be ignored
    base = done_cnt;
    A = 4'd6; B = 4'd2; start = 1'b1;
    push(4'd6, 4'd2);
    tick();
    A = 4'd1; B = 4'd15;
    tick();
    tick();
    start = 1'b0;
    wait_done(n, bc);
    for (int i = 0; i < 4; i++) tick();
    chk("single_done", done_cnt - base, 32'd1);

    // back-to-back: start held high through DONE
    A = 4'd10; B = 4'd3; start = 1'b1;
    push(4'd10, 4'd3);
    tick();
    A = 4'd12; B = 4'd4;
    wait_done(n, bc);
    push(4'd12, 4'd4);
    tick();
    start = 1'b0;
    chk("hold_shift", diferenca, 32'd7);
    gap = 1;
    while (done !== 1'b1 && gap < 30) begin
      tick();
      gap++;
    end
    chk("b2b_gap", gap, 32'd5);
    chk("b2b_result", diferenca, 32'd8);
    tick();

    // reset during the second SHIFT cycle aborts the operation
    A = 4'd13; B = 4'd2; start = 1'b1;
    push(4'd13, 4'd2);
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dif", diferenca, 32'd0);
    chk("abort_borrow", {31'd0, borrow}, 32'd0);
    sbq.delete();
    base = done_cnt;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_done", done_cnt - base, 32'd0);
    run_op(4'd8, 4'd1);
    chk("after_abort", diferenca, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
